// File: rtl/midi_pkg.sv
// Shared constants for the MIDI note receiver: status nibbles,
// controller numbers and FSM state encodings.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] CTRL     = 4'hB;

    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'h7B;
    localparam logic [7:0] RT_MIN           = 8'hF8;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] P_WAIT_STATUS = 2'd0;
    localparam logic [1:0] P_WAIT_D1     = 2'd1;
    localparam logic [1:0] P_WAIT_D2     = 2'd2;

endpackage

// File: rtl/midi_note_rx_if.sv
// Note-event bundle produced by the MIDI parser.
interface midi_note_rx_if;

    logic       valid;
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;

    modport master (output valid, output on, output note, output vel);
    modport slave  (input valid, input on, input note, input vel);

endinterface

// File: rtl/midi_uart_rx.sv
// Oversampling 8N1 serial receiver for the MIDI line.
module midi_uart_rx #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 31250,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk25,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);
    import midi_pkg::*;

    localparam int DIV  = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW   = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL = SW'(OVERSAMPLE - 1);

    logic [1:0]    sync;
    logic          rx_s;
    logic          rx_d;
    logic          fall;
    logic [CW-1:0] div_cnt;
    logic          tick;
    logic [1:0]    state;
    logic [SW-1:0] scnt;
    logic [2:0]    bcnt;
    logic [7:0]    shift;
    logic          brk;

    assign rx_s = sync[1];
    assign fall = rx_d & ~rx_s;
    assign tick = (div_cnt == CW'(DIV - 1));
    assign data = shift;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            rx_d    <= 1'b1;
            div_cnt <= '0;
        end else begin
            sync    <= {sync[0], rx};
            rx_d    <= rx_s;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            scnt       <= '0;
            bcnt       <= '0;
            shift      <= '0;
            brk        <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (fall) begin
                        state <= RX_START;
                        scnt  <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (scnt == HALF) begin
                            state <= rx_s ? RX_IDLE : RX_DATA;
                            scnt  <= '0;
                            bcnt  <= '0;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (scnt == FULL) begin
                            scnt  <= '0;
                            shift <= {rx_s, shift[7:1]};
                            bcnt  <= bcnt + 1'b1;
                            if (bcnt == 3'd7) state <= RX_STOP;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    // After a bad stop bit, wait out the low line
                    if (brk) begin
                        if (rx_s) begin
                            brk   <= 1'b0;
                            state <= RX_IDLE;
                        end
                    end else if (tick) begin
                        if (scnt == FULL) begin
                            scnt <= '0;
                            if (rx_s) begin
                                byte_valid <= 1'b1;
                                state      <= RX_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                brk       <= 1'b1;
                            end
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/midi_note_rx.sv
// MIDI note receiver: serial byte receiver plus running-status parser
// driving a held-key bitmap. MIDI_ALL_NOTES_OFF_EN enables CC 0x7B.
`ifndef NKEYS
`define NKEYS 128
`endif
module midi_note_rx #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 31250,
    parameter int OVERSAMPLE = 16,
    parameter int NKEYS      = `NKEYS,
    parameter int KEY_BASE   = 0,
    parameter int CHANNEL    = 16
) (
    input  logic             clk25,
    input  logic             rst_n,
    input  logic             rx,
    output logic [NKEYS-1:0] key_status,
    output logic             evt_valid,
    output logic             evt_on,
    output logic [6:0]       evt_note,
    output logic [6:0]       evt_vel,
    output logic             frame_err
);
    import midi_pkg::*;

    logic [7:0]       b;
    logic             bv;
    logic [1:0]       pstate;
    logic [7:0]       rstat;
    logic             rs_ok;
    logic [6:0]       d1;
    logic [3:0]       hi;
    logic             is_rt, is_sys, is_stat, is_data;
    logic             one_data, take, done;
    logic [6:0]       m_note, m_vel;
    logic             chan_ok, in_rng, is_on, note_hit;
    logic [NKEYS-1:0] mask;
    int               idx;

    midi_note_rx_if ev ();

    midi_uart_rx #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_rx (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (b),
        .byte_valid(bv),
        .frame_err (frame_err)
    );

    assign hi = rstat[7:4];

    always_comb begin
        is_rt    = (b >= RT_MIN);
        is_sys   = (b[7:4] == 4'hF) && !is_rt;
        is_stat  = b[7] && (b[7:4] != 4'hF);
        is_data  = !b[7];
        one_data = (hi == 4'hC) || (hi == 4'hD);
        take     = bv && is_data && (pstate != P_WAIT_STATUS || rs_ok);
        done     = take && (pstate == P_WAIT_D2 || one_data);
        m_note   = (pstate == P_WAIT_D2) ? d1 : b[6:0];
        m_vel    = (pstate == P_WAIT_D2) ? b[6:0] : 7'd0;
        chan_ok  = (CHANNEL > 15) || (rstat[3:0] == 4'(CHANNEL));
        idx      = int'(m_note) - KEY_BASE;
        in_rng   = (idx >= 0) && (idx < NKEYS);
        mask     = in_rng ? (NKEYS'(1) << idx) : '0;
        is_on    = (hi == NOTE_ON) && (m_vel != 7'd0);
        note_hit = done && chan_ok && in_rng &&
                   (hi == NOTE_OFF || hi == NOTE_ON);
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            pstate     <= P_WAIT_STATUS;
            rstat      <= '0;
            rs_ok      <= 1'b0;
            d1         <= '0;
            key_status <= '0;
            ev.valid   <= 1'b0;
            ev.on      <= 1'b0;
            ev.note    <= '0;
            ev.vel     <= '0;
        end else begin
            ev.valid <= 1'b0;
            if (bv) begin
                unique case (1'b1)
                    is_rt: ;
                    is_sys: begin
                        rs_ok  <= 1'b0;
                        pstate <= P_WAIT_STATUS;
                    end
                    is_stat: begin
                        rstat  <= b;
                        rs_ok  <= 1'b1;
                        pstate <= P_WAIT_D1;
                    end
                    is_data: begin
                        if (done) begin
                            pstate <= P_WAIT_D1;
                        end else if (take) begin
                            d1     <= b[6:0];
                            pstate <= P_WAIT_D2;
                        end
                    end
                    default: ;
                endcase
            end
            if (note_hit) begin
                key_status <= is_on ? (key_status | mask)
                                    : (key_status & ~mask);
                ev.valid   <= 1'b1;
                ev.on      <= is_on;
                ev.note    <= m_note;
                ev.vel     <= m_vel;
            end
`ifdef MIDI_ALL_NOTES_OFF_EN
            if (done && chan_ok && hi == CTRL &&
                m_note == CC_ALL_NOTES_OFF)
                key_status <= '0;
`else
`endif
        end
    end

    assign evt_valid = ev.valid;
    assign evt_on    = ev.on;
    assign evt_note  = ev.note;
    assign evt_vel   = ev.vel;

endmodule

// File: tb/tb_midi_note_rx.sv
// Scoreboard bench: an omni receiver and a channel-3 receiver share one rx line.
`timescale 1ns/1ps
module tb_midi_note_rx;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 31250;
    localparam int OS     = 8;
    localparam int DIV    = CLK_HZ / (BAUD * OS);
    localparam int BIT    = DIV * OS;

    logic         clk25 = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx    = 1'b1;
    logic [127:0] key_status;
    logic         evt_valid, evt_on, frame_err;
    logic [6:0]   evt_note, evt_vel;
    logic [63:0]  key3;
    logic         ev3_valid, ev3_on, ferr3;
    logic [6:0]   ev3_note, ev3_vel;

    always #5 clk25 = ~clk25;

    midi_note_rx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
        .NKEYS(128), .KEY_BASE(0), .CHANNEL(16)
    ) dut (
        .clk25(clk25), .rst_n(rst_n), .rx(rx),
        .key_status(key_status), .evt_valid(evt_valid),
        .evt_on(evt_on), .evt_note(evt_note), .evt_vel(evt_vel),
        .frame_err(frame_err)
    );

    midi_note_rx #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
        .NKEYS(64), .KEY_BASE(4), .CHANNEL(3)
    ) dut3 (
        .clk25(clk25), .rst_n(rst_n), .rx(rx),
        .key_status(key3), .evt_valid(ev3_valid),
        .evt_on(ev3_on), .evt_note(ev3_note), .evt_vel(ev3_vel),
        .frame_err(ferr3)
    );

    midi_note_rx_if mon ();
    assign mon.valid = evt_valid;
    assign mon.on    = evt_on;
    assign mon.note  = evt_note;
    assign mon.vel   = evt_vel;

    int errors = 0;
    int checks = 0;
    logic [14:0] exp_q[$];
    int cyc = 0, bv_cyc = -10, ferr_n = 0, ev3_n = 0, bytes_n = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk25) cyc <= cyc + 1;

    always @(negedge clk25) begin
        if (dut.u_rx.byte_valid) begin
            bv_cyc = cyc;
            bytes_n++;
        end
        if (frame_err) ferr_n++;
        if (ev3_valid) ev3_n++;
        if (mon.valid) begin
            check("evt_latency", cyc - bv_cyc, 1);
            check("evt_key_bit", key_status[mon.note], mon.on);
            if (exp_q.size() == 0)
                check("evt_unexpected", exp_q.size(), 1);
            else
                check("evt", {mon.on, mon.note, mon.vel}, exp_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk25);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT);
        end
        rx = stop;
        tick(BIT);
        rx = 1'b1;
        tick(BIT);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic do_reset();
        rx    = 1'b1;
        rst_n = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic expect_evt(input logic on, input logic [6:0] n,
                              input logic [6:0] v);
        exp_q.push_back({on, n, v});
    endtask

    int n0;

    initial begin
        tick(3);
        check("rst_keys", 32'(|key_status), 0);
        check("rst_keys3", 32'(|key3), 0);
        check("rst_outs", {evt_valid, evt_on, evt_note, evt_vel, frame_err}, 0);
        rst_n = 1'b1;
        tick(4);

        expect_evt(1, 60, 100);
        send(8'h90); send(8'h3C); send(8'h64);
        check("on_key60", key_status[60], 1);
        check("on_popcnt", $countones(key_status), 1);
        check("on_pending", exp_q.size(), 0);

        do_reset();
        expect_evt(1, 60, 100);
        expect_evt(1, 64, 80);
        expect_evt(0, 60, 0);
        send(8'h90); send(8'h3C); send(8'h64);
        send(8'h40); send(8'h50); send(8'h3C); send(8'h00);
        check("rs_key64", key_status[64], 1);
        check("rs_key60", key_status[60], 0);
        check("rs_pending", exp_q.size(), 0);

        do_reset();
        expect_evt(1, 60, 100);
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
        check("rt_key60", key_status[60], 1);
        check("rt_pending", exp_q.size(), 0);
        n0 = bytes_n;
        rx = 1'b0;
        tick(2 * DIV);
        rx = 1'b1;
        tick(4 * BIT);
        check("glitch_bytes", bytes_n, n0);

        do_reset();
        n0 = ferr_n;
        send_frame(8'h90, 1'b0);
        send(8'h3C); send(8'h64);
        check("ferr_count", ferr_n - n0, 1);
        check("ferr_key60", key_status[60], 0);

        do_reset();
        send(8'h90); send(8'h3C);
        rx = 1'b0;
        tick(4 * BIT);
        rst_n = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(BIT);
        send(8'h64); send(8'h3C); send(8'h64);
        check("midrst_key60", key_status[60], 0);
        expect_evt(1, 60, 100);
        send(8'h90); send(8'h3C); send(8'h64);
        check("resume_key60", key_status[60], 1);

        do_reset();
        n0 = ev3_n;
        expect_evt(1, 60, 100);
        send(8'h91); send(8'h3C); send(8'h64);
        check("ch1_key3", key3[56], 0);
        check("ch1_evt3", ev3_n - n0, 0);
        expect_evt(1, 60, 100);
        send(8'h93); send(8'h3C); send(8'h64);
        check("ch3_key3", key3[56], 1);
        check("repeat_key60", key_status[60], 1);
        expect_evt(1, 3, 64);
        send(8'h03); send(8'h40);
        expect_evt(1, 68, 64);
        send(8'h44); send(8'h40);
        expect_evt(1, 4, 127);
        send(8'h04); send(8'h7F);
        expect_evt(1, 67, 1);
        send(8'h43); send(8'h01);
        check("ch3_bit0", key3[0], 1);
        check("ch3_bit63", key3[63], 1);
        check("ch3_popcnt", $countones(key3), 3);
        check("ch3_evts", ev3_n - n0, 3);
        expect_evt(0, 67, 0);
        send(8'h83); send(8'h43); send(8'h00);
        check("off_key3", key3[63], 0);
        check("off_key67", key_status[67], 0);
        check("ch3_pending", exp_q.size(), 0);

        do_reset();
        expect_evt(1, 60, 100);
        expect_evt(1, 64, 80);
        send(8'h90); send(8'h3C); send(8'h64); send(8'h40); send(8'h50);
        check("held_popcnt", $countones(key_status), 2);
        send(8'hB0); send(8'h7B); send(8'h00);
`ifdef MIDI_ALL_NOTES_OFF_EN
        check("ano_popcnt", $countones(key_status), 0);
`else
        check("ano_key60", key_status[60], 1);
        check("ano_key64", key_status[64], 1);
`endif
        tick(BIT);
        check("final_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/midi_note_rx.md
MIDI_NOTE_RX -- requirements
Module: midi_note_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000: clk25 frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250: serial bit rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16: sample ticks per bit, even, >= 8.
REQ-004 SHALL have parameter NKEYS, default `NKEYS: key_status width.
REQ-005 SHALL have parameter KEY_BASE, default 0: MIDI note mapped to key_status[0].
REQ-006 SHALL have parameter CHANNEL, default 16: channel filter; 0-15 selects one channel, 16 accepts all (omni).
REQ-007 SHALL have port clk25, input, 1: sole clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous reset, active-low.
REQ-009 SHALL have port rx, input, 1: asynchronous MIDI serial line; idle high.
REQ-010 SHALL have port key_status, output, NKEYS: held-key bitmap.
REQ-011 SHALL have port evt_valid, output, 1: one-cycle note-event strobe.
REQ-012 SHALL have port evt_on, output, 1: 1 = note on, 0 = note off; valid with evt_valid.
REQ-013 SHALL have port evt_note, output, 7: MIDI note number; valid with evt_valid.
REQ-014 SHALL have port evt_vel, output, 7: velocity; valid with evt_valid.
REQ-015 SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit.

Function
REQ-016 SHALL pass rx through a 2-flop synchroniser before any use.
REQ-017 SHALL generate a sample tick every CLK_HZ/(BAUD*OVERSAMPLE) cycles (integer division) from a free-running counter that wraps to 0.
REQ-018 Receiver FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE->START on a synchronised falling edge.
- START->DATA if rx is 0 at tick OVERSAMPLE/2; otherwise START->IDLE (glitch rejected).
- DATA samples 8 bits LSB-first, one every OVERSAMPLE ticks after the start-bit midpoint.
REQ-019 In STOP, a mid-bit sample of 1 SHALL raise the internal byte_valid for 1 cycle; a sample of 0 SHALL pulse frame_err for 1 cycle, discard the byte, and hold until rx is high before returning to IDLE.
REQ-020 Parser FSM SHALL have states WAIT_STATUS, WAIT_D1, WAIT_D2, driven by received bytes.
- Bytes 0xF8-0xFF SHALL be ignored in any state, without changing state or running status.
- Bytes 0xF0-0xF7 SHALL invalidate running status and go to WAIT_STATUS.
- Bytes 0x80-0xEF SHALL latch as running status and go to WAIT_D1, aborting any partial message.
- Data bytes (bit7 = 0) in WAIT_STATUS SHALL be treated as D1 if running status is valid; otherwise discarded.
- Messages 0xCn and 0xDn complete after D1; all others complete after D2.
- On completion the parser SHALL return to WAIT_D1 with running status retained.
REQ-021 On completion of a 0x8n or 0x9n message whose channel passes the filter, with idx = note-KEY_BASE:
- 0x9n with velocity > 0 SHALL set key_status[idx].
- 0x8n, or 0x9n with velocity 0, SHALL clear key_status[idx].
- evt_valid SHALL pulse with evt_on, evt_note and evt_vel; for 0x9n with velocity 0, evt_on = 0.
- If idx falls outside 0..NKEYS-1: no key_status change and no evt_valid.
- All other message types SHALL be consumed with no output effect.
REQ-022 Latency: a final data byte with byte_valid in cycle N SHALL update key_status and evt_valid in cycle N+1.
REQ-023 A repeated note-on for a held key SHALL leave its bit at 1 and still pulse evt_valid.

Reset
REQ-024 While rst_n = 0, key_status, evt_* and frame_err SHALL be 0, both FSMs SHALL be in IDLE/WAIT_STATUS, running status SHALL be invalid and the tick counter SHALL be 0.
REQ-025 Reset asserted mid-byte or mid-message SHALL discard the partial data; after release, reception SHALL resume at the next falling edge.

Configuration
REQ-026 With MIDI_ALL_NOTES_OFF_EN defined, a filter-passing 0xBn 0x7B xx message SHALL clear all of key_status in the cycle after completion, with no evt_valid.
REQ-027 Without MIDI_ALL_NOTES_OFF_EN, 0xBn messages SHALL have no effect.

Structure
REQ-028 A shared package midi_pkg SHALL hold the status nibble codes (NOTE_OFF 4'h8, NOTE_ON 4'h9, CTRL 4'hB), CC_ALL_NOTES_OFF 7'h7B, the realtime threshold 8'hF8 and the FSM state encodings.
REQ-029 The serial receiver (REQ-016..019) SHALL be a sub-module midi_uart_rx with outputs data[7:0], byte_valid and frame_err.

Verification
REQ-030 Send 0x90 0x3C 0x64 -> key_status[60] = 1; one evt_valid with on = 1, note = 60, vel = 100.
REQ-031 Send 0x90 0x3C 0x64 0x40 0x50 0x3C 0x00 -> bit 64 = 1, bit 60 = 0; three events, the last with on = 0.
REQ-032 Send 0x90 0xF8 0x3C 0xFE 0x64 -> same result as REQ-030; also send a 2-tick low glitch on rx -> no byte received.
REQ-033 Send 0x90 with stop bit 0, then 0x3C 0x64 -> frame_err pulses once; no key change and no event.
REQ-034 With CHANNEL = 3: send 0x91 0x3C 0x64 -> no effect; send 0x93 0x3C 0x64 -> key_status[60] = 1.
REQ-035 Hold keys 60 and 64, then send 0xB0 0x7B 0x00 -> key_status = 0 with MIDI_ALL_NOTES_OFF_EN defined; unchanged without it.
